// File: rtl/apb_to_axi_bridge_if.sv
// APB responder + single-beat AXI manager signal bundle for apb_to_axi_bridge.
interface apb_to_axi_bridge_if #(
  parameter int AXI_WIDTH_ID = 4,
  parameter int AXI_WIDTH_AD = 32,
  parameter int AXI_WIDTH_DA = 32
);
  localparam int AXI_WIDTH_DS = AXI_WIDTH_DA / 8;

  logic                    PSEL;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [AXI_WIDTH_AD-1:0] PADDR;
  logic [AXI_WIDTH_DA-1:0] PWDATA;
  logic [AXI_WIDTH_DS-1:0] PSTRB;
  logic [2:0]              PPROT;
  logic [AXI_WIDTH_DA-1:0] PRDATA;
  logic                    PREADY;
  logic                    PSLVERR;

  logic [AXI_WIDTH_ID-1:0] AWID;
  logic [AXI_WIDTH_AD-1:0] AWADDR;
  logic [3:0]              AWLEN;
  logic [2:0]              AWSIZE;
  logic [1:0]              AWBURST;
  logic [2:0]              AWPROT;
  logic                    AWVALID;
  logic                    AWREADY;

  logic [AXI_WIDTH_ID-1:0] WID;
  logic [AXI_WIDTH_DA-1:0] WDATA;
  logic [AXI_WIDTH_DS-1:0] WSTRB;
  logic                    WLAST;
  logic                    WVALID;
  logic                    WREADY;

  logic [AXI_WIDTH_ID-1:0] BID;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;

  logic [AXI_WIDTH_ID-1:0] ARID;
  logic [AXI_WIDTH_AD-1:0] ARADDR;
  logic [3:0]              ARLEN;
  logic [2:0]              ARSIZE;
  logic [1:0]              ARBURST;
  logic [2:0]              ARPROT;
  logic                    ARVALID;
  logic                    ARREADY;

  logic [AXI_WIDTH_ID-1:0] RID;
  logic [AXI_WIDTH_DA-1:0] RDATA;
  logic [1:0]              RRESP;
  logic                    RLAST;
  logic                    RVALID;
  logic                    RREADY;

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    output PRDATA, PREADY, PSLVERR,
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWPROT, AWVALID,
    input  AWREADY,
    output WID, WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARPROT, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    input  PRDATA, PREADY, PSLVERR,
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWPROT, AWVALID,
    output AWREADY,
    input  WID, WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARPROT, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );
endinterface

// File: rtl/apb_to_axi_bridge.sv
// APB responder to single-beat AXI manager; one transaction in flight,
// APB access phase is stretched until the AXI response returns.
module apb_to_axi_bridge #(
  parameter int AXI_WIDTH_ID = 4,
  parameter int AXI_WIDTH_AD = 32,
  parameter int AXI_WIDTH_DA = 32,
  parameter int AXI_ID       = 0
) (
  input logic PCLK,
  input logic PRESET,
  apb_to_axi_bridge_if.slave bus
);
  localparam int AXI_WIDTH_DS = AXI_WIDTH_DA / 8;
  localparam logic [AXI_WIDTH_ID-1:0] ID_C = AXI_WIDTH_ID'(AXI_ID);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_REQ  = 3'd1;
  localparam logic [2:0] WR_RESP = 3'd2;
  localparam logic [2:0] RD_REQ  = 3'd3;
  localparam logic [2:0] RD_DATA = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  logic [2:0]              state_q, state_d;
  logic [AXI_WIDTH_AD-1:0] addr_q, addr_d;
  logic [AXI_WIDTH_DA-1:0] wdata_q, wdata_d;
  logic [AXI_WIDTH_DS-1:0] strb_q, strb_d;
  logic [2:0]              prot_q, prot_d;
  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q, wvalid_d;
  logic                    arvalid_q, arvalid_d;
  logic [AXI_WIDTH_DA-1:0] prdata_q, prdata_d;
  logic                    pslverr_q, pslverr_d;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    prot_d    = prot_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    prdata_d  = prdata_q;
    pslverr_d = pslverr_q;
    unique case (state_q)
      IDLE: begin
        if (bus.PSEL && !bus.PENABLE) begin
          addr_d  = bus.PADDR;
          wdata_d = bus.PWDATA;
          strb_d  = bus.PSTRB;
          prot_d  = bus.PPROT;
          if (bus.PWRITE) begin
            state_d   = WR_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD_REQ;
            arvalid_d = 1'b1;
          end
        end
      end
      WR_REQ: begin
        // AW and W complete independently, in either order
        if (bus.AWREADY) awvalid_d = 1'b0;
        if (bus.WREADY)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (bus.BVALID) begin
          pslverr_d = bus.BRESP[1];
          state_d   = DONE;
        end
      end
      RD_REQ: begin
        if (bus.ARREADY) begin
          arvalid_d = 1'b0;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (bus.RVALID) begin
          prdata_d  = bus.RDATA;
          pslverr_d = bus.RRESP[1];
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      prot_q    <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      prot_q    <= prot_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
    end
  end

  assign bus.PREADY  = (state_q == DONE);
  assign bus.PSLVERR = (state_q == DONE) && pslverr_q;
  assign bus.PRDATA  = prdata_q;

  assign bus.AWID    = ID_C;
  assign bus.AWADDR  = addr_q;
  assign bus.AWLEN   = 4'd0;
  assign bus.AWSIZE  = 3'b010;
  assign bus.AWBURST = 2'b01;
  assign bus.AWPROT  = prot_q;
  assign bus.AWVALID = awvalid_q;

  assign bus.WID     = ID_C;
  assign bus.WDATA   = wdata_q;
  assign bus.WSTRB   = strb_q;
  assign bus.WLAST   = 1'b1;
  assign bus.WVALID  = wvalid_q;

  assign bus.BREADY  = (state_q == WR_RESP);

  assign bus.ARID    = ID_C;
  assign bus.ARADDR  = addr_q;
  assign bus.ARLEN   = 4'd0;
  assign bus.ARSIZE  = 3'b010;
  assign bus.ARBURST = 2'b01;
  assign bus.ARPROT  = prot_q;
  assign bus.ARVALID = arvalid_q;

  assign bus.RREADY  = (state_q == RD_DATA);

  // IDs and low response bits carry no information with one outstanding
  logic unused_ok;
  assign unused_ok = &{1'b0, bus.BID, bus.BRESP[0], bus.RID,
                       bus.RRESP[0], bus.RLAST};
endmodule

// File: tb/tb_apb_to_axi_bridge.sv
// Directed table + corner sequences + random traffic for apb_to_axi_bridge.
module tb_apb_to_axi_bridge;
  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  apb_to_axi_bridge_if #(.AXI_WIDTH_ID(4), .AXI_WIDTH_AD(32),
                         .AXI_WIDTH_DA(32)) bus ();

  apb_to_axi_bridge #(
    .AXI_WIDTH_ID(4), .AXI_WIDTH_AD(32), .AXI_WIDTH_DA(32), .AXI_ID(5)
  ) dut (
    .PCLK(clk), .PRESET(rst), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // ---------------- AXI responder with memory ----------------
  logic [31:0] mem [logic [31:0]];
  int   aw_wait_cfg = 0, w_wait_cfg = 0, b_wait_cfg = 0;
  int   ar_wait_cfg = 0, r_wait_cfg = 0;
  logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic rand_mode = 1'b0;
  logic stray = 1'b0, stray_on = 1'b0;
  int   aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic busy, aw_got, w_got, ar_got;
  logic aw_fire, w_fire, ar_fire, b_fire, r_fire;
  logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
  logic [3:0]  cap_wstrb;
  logic [2:0]  cap_awprot, cap_arprot;
  int   b_hs = 0, r_hs = 0, awv_cyc = 0, wv_cyc = 0;

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  task resp_clear;
    bus.AWREADY = 0; bus.WREADY = 0; bus.ARREADY = 0;
    bus.BVALID = 0; bus.BRESP = 0; bus.BID = 0;
    bus.RVALID = 0; bus.RRESP = 0; bus.RID = 0;
    bus.RDATA = 0; bus.RLAST = 0;
    busy = 0; aw_got = 0; w_got = 0; ar_got = 0;
    aw_fire = 0; w_fire = 0; ar_fire = 0; b_fire = 0; r_fire = 0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    stray_on = 0;
  endtask

  task axi_step;
    logic [31:0] m;
    if (!busy && (bus.AWVALID || bus.ARVALID)) begin
      busy = 1;
      if (rand_mode) begin
        aw_cnt = int'($urandom_range(3, 0));
        w_cnt  = int'($urandom_range(3, 0));
        b_cnt  = int'($urandom_range(3, 0));
        ar_cnt = int'($urandom_range(3, 0));
        r_cnt  = int'($urandom_range(3, 0));
      end else begin
        aw_cnt = aw_wait_cfg; w_cnt = w_wait_cfg; b_cnt = b_wait_cfg;
        ar_cnt = ar_wait_cfg; r_cnt = r_wait_cfg;
      end
    end
    if (b_fire) begin
      bus.BVALID = 0; b_fire = 0;
    end else if (!bus.BVALID && aw_got && w_got) begin
      if (b_cnt != 0) b_cnt--;
      else begin
        for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{cap_wstrb[i]}};
        mem[cap_awaddr] = (rd_mem(cap_awaddr) & ~m) | (cap_wdata & m);
        bus.BVALID = 1; bus.BRESP = bresp_cfg;
        bus.BID = 4'($urandom_range(15, 0));
        aw_got = 0; w_got = 0; busy = 0;
      end
    end
    if (bus.BVALID && !b_fire && bus.BREADY) begin
      b_fire = 1; b_hs++;
    end
    if (r_fire) begin
      bus.RVALID = 0; r_fire = 0;
    end else if (!bus.RVALID && ar_got) begin
      if (r_cnt != 0) r_cnt--;
      else begin
        bus.RVALID = 1; bus.RRESP = rresp_cfg; bus.RLAST = 1;
        bus.RDATA = rd_mem(cap_araddr);
        bus.RID = 4'($urandom_range(15, 0));
        ar_got = 0; busy = 0;
      end
    end
    if (bus.RVALID && !r_fire && bus.RREADY) begin
      r_fire = 1; r_hs++;
    end
    if (aw_fire) begin
      bus.AWREADY = 0; aw_fire = 0;
    end else if (bus.AWVALID && !aw_got) begin
      if (aw_cnt != 0) aw_cnt--;
      else begin
        bus.AWREADY = 1; aw_fire = 1; aw_got = 1;
        cap_awaddr = bus.AWADDR; cap_awprot = bus.AWPROT;
      end
    end
    if (w_fire) begin
      bus.WREADY = 0; w_fire = 0;
    end else if (bus.WVALID && !w_got) begin
      if (w_cnt != 0) w_cnt--;
      else begin
        bus.WREADY = 1; w_fire = 1; w_got = 1;
        cap_wdata = bus.WDATA; cap_wstrb = bus.WSTRB;
      end
    end
    if (ar_fire) begin
      bus.ARREADY = 0; ar_fire = 0;
    end else if (bus.ARVALID && !ar_got) begin
      if (ar_cnt != 0) ar_cnt--;
      else begin
        bus.ARREADY = 1; ar_fire = 1; ar_got = 1;
        cap_araddr = bus.ARADDR; cap_arprot = bus.ARPROT;
      end
    end
  endtask

  initial begin
    mem[32'h0002_0010] = 32'h1234_5678;
    resp_clear();
    forever begin
      @(negedge clk);
      if (rst) resp_clear();
      else if (stray) begin
        bus.BVALID = 1; bus.RVALID = 1; bus.BRESP = 2'b10;
        bus.RRESP = 2'b10; bus.RDATA = 32'hFFFF_FFFF; stray_on = 1;
      end else if (stray_on) begin
        bus.BVALID = 0; bus.RVALID = 0; bus.BRESP = 0;
        bus.RRESP = 0; stray_on = 0;
      end else axi_step();
    end
  end

  initial forever begin
    @(negedge clk);
    if (bus.AWVALID) awv_cyc++;
    if (bus.WVALID)  wv_cyc++;
  end

  // ---------------- APB requester ----------------
  task automatic apb_idle;
    @(posedge clk); #1;
    bus.PSEL = 0; bus.PENABLE = 0;
  endtask

  task automatic apb_xfer(input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          input logic [2:0] prot, input logic drop,
                          output logic [31:0] rdata, output logic err,
                          output int lat);
    @(posedge clk); #1;
    bus.PSEL = 1; bus.PENABLE = 0; bus.PWRITE = wr;
    bus.PADDR = addr; bus.PWDATA = wdata; bus.PSTRB = strb;
    bus.PPROT = prot;
    lat = 1;
    @(posedge clk); #1;
    if (drop) begin
      bus.PSEL = 0; bus.PENABLE = 0;
      bus.PADDR = '1; bus.PWDATA = '1;
    end else bus.PENABLE = 1;
    lat = 2; rdata = 0; err = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (bus.PREADY) begin
        rdata = bus.PRDATA; err = bus.PSLVERR;
        return;
      end
      lat++;
    end
    total++; bad++;
    $display("FAIL apb timeout %h: got no PREADY want PREADY", addr);
    lat = -1;
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    logic [1:0]  resp;
    int          aw_w, w_w, b_w, ar_w, r_w;
    logic [31:0] rdata;
    logic        err;
    int          lat, awv, wv;
  } vec_t;

  function automatic vec_t mkw(logic [31:0] a, logic [31:0] d,
      logic [3:0] s, logic [2:0] p, logic [1:0] rs, int aw, int w,
      int b, logic e, int l, int av, int wv);
    vec_t v;
    v.wr = 1; v.addr = a; v.wdata = d; v.strb = s; v.prot = p;
    v.resp = rs; v.aw_w = aw; v.w_w = w; v.b_w = b; v.ar_w = 0;
    v.r_w = 0; v.rdata = 0; v.err = e; v.lat = l; v.awv = av; v.wv = wv;
    return v;
  endfunction

  function automatic vec_t mkr(logic [31:0] a, logic [2:0] p,
      logic [1:0] rs, int ar, int r, logic [31:0] d, logic e, int l);
    vec_t v;
    v.wr = 0; v.addr = a; v.wdata = 0; v.strb = 0; v.prot = p;
    v.resp = rs; v.aw_w = 0; v.w_w = 0; v.b_w = 0; v.ar_w = ar;
    v.r_w = r; v.rdata = d; v.err = e; v.lat = l; v.awv = 0; v.wv = 0;
    return v;
  endfunction

  vec_t        vt [10];
  logic [31:0] sb [8];
  logic [31:0] rd, last_rd, a;
  logic        er;
  int          lat, b0, r0, a0, w0, idx;

  initial begin
    vt[0] = mkw(32'h0001_0004, 32'hDEAD_BEEF, 4'hF, 3'b000, 2'b00,
                0, 0, 0, 1'b0, 4, 1, 1);
    vt[1] = mkr(32'h0002_0010, 3'b000, 2'b00, 0, 0,
                32'h1234_5678, 1'b0, 4);
    vt[2] = mkw(32'h0003_0000, 32'hCAFE_F00D, 4'hF, 3'b010, 2'b00,
                3, 0, 0, 1'b0, 7, 4, 1);
    vt[3] = mkw(32'h0004_0000, 32'h0BAD_C0DE, 4'hF, 3'b000, 2'b00,
                0, 2, 1, 1'b0, 7, 1, 3);
    vt[4] = mkw(32'h0005_0000, 32'h0000_0055, 4'hF, 3'b000, 2'b10,
                0, 0, 0, 1'b1, 4, 1, 1);
    vt[5] = mkr(32'h0002_0010, 3'b101, 2'b11, 0, 0,
                32'h1234_5678, 1'b1, 4);
    vt[6] = mkw(32'h0001_0004, 32'h1122_3344, 4'h5, 3'b000, 2'b01,
                1, 1, 0, 1'b0, 5, 2, 2);
    vt[7] = mkr(32'h0001_0004, 3'b000, 2'b01, 2, 1,
                32'hDE22_BE44, 1'b0, 7);
    vt[8] = mkw(32'h0006_0000, 32'h0000_0000, 4'hF, 3'b111, 2'b11,
                0, 0, 0, 1'b1, 4, 1, 1);
    vt[9] = mkr(32'h0003_0000, 3'b000, 2'b10, 0, 0,
                32'hCAFE_F00D, 1'b1, 4);

    rst = 1;
    bus.PSEL = 0; bus.PENABLE = 0; bus.PWRITE = 0; bus.PADDR = 0;
    bus.PWDATA = 0; bus.PSTRB = 0; bus.PPROT = 0;
    @(negedge clk); @(negedge clk); #1;
    chk("rst ctl", 32'({bus.PREADY, bus.PSLVERR, bus.AWVALID,
        bus.WVALID, bus.ARVALID, bus.BREADY, bus.RREADY}), 32'h0);
    chk("rst prdata", bus.PRDATA, 32'h0);
    chk("rst addr", bus.AWADDR | bus.ARADDR | bus.WDATA, 32'h0);
    chk("const", 32'({bus.AWLEN, bus.ARLEN, bus.AWSIZE, bus.ARSIZE,
        bus.AWBURST, bus.ARBURST, bus.WLAST}),
        32'({4'h0, 4'h0, 3'b010, 3'b010, 2'b01, 2'b01, 1'b1}));
    chk("ids", 32'({bus.AWID, bus.WID, bus.ARID}), 32'h555);
    @(posedge clk); #1 rst = 0;

    last_rd = 32'h0;
    for (int i = 0; i < 10; i++) begin
      aw_wait_cfg = vt[i].aw_w; w_wait_cfg = vt[i].w_w;
      b_wait_cfg = vt[i].b_w; ar_wait_cfg = vt[i].ar_w;
      r_wait_cfg = vt[i].r_w;
      bresp_cfg = vt[i].resp; rresp_cfg = vt[i].resp;
      b0 = b_hs; r0 = r_hs; a0 = awv_cyc; w0 = wv_cyc;
      apb_xfer(vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].strb,
               vt[i].prot, 1'b0, rd, er, lat);
      chk($sformatf("v%0d err", i), 32'(er), 32'(vt[i].err));
      chk($sformatf("v%0d lat", i), 32'(lat), 32'(vt[i].lat));
      if (vt[i].wr) begin
        chk($sformatf("v%0d awaddr", i), cap_awaddr, vt[i].addr);
        chk($sformatf("v%0d wdata", i), cap_wdata, vt[i].wdata);
        chk($sformatf("v%0d wstrb", i), 32'(cap_wstrb), 32'(vt[i].strb));
        chk($sformatf("v%0d awprot", i), 32'(cap_awprot), 32'(vt[i].prot));
        chk($sformatf("v%0d b_hs", i), 32'(b_hs - b0), 32'd1);
        chk($sformatf("v%0d awv_cyc", i), 32'(awv_cyc - a0),
            32'(vt[i].awv));
        chk($sformatf("v%0d wv_cyc", i), 32'(wv_cyc - w0), 32'(vt[i].wv));
        chk($sformatf("v%0d prdata hold", i), rd, last_rd);
      end else begin
        chk($sformatf("v%0d rdata", i), rd, vt[i].rdata);
        chk($sformatf("v%0d araddr", i), cap_araddr, vt[i].addr);
        chk($sformatf("v%0d arprot", i), 32'(cap_arprot), 32'(vt[i].prot));
        chk($sformatf("v%0d r_hs", i), 32'(r_hs - r0), 32'd1);
        last_rd = vt[i].rdata;
      end
    end

    // stray B/R responses while idle must be ignored
    apb_idle();
    bresp_cfg = 0; rresp_cfg = 0;
    stray = 1;
    repeat (3) @(negedge clk);
    #1;
    chk("stray ctl", 32'({bus.PREADY, bus.BREADY, bus.RREADY,
        bus.AWVALID, bus.WVALID, bus.ARVALID}), 32'h0);
    chk("stray prdata", bus.PRDATA, last_rd);
    stray = 0;
    repeat (2) @(negedge clk);

    // PSEL dropped mid-access: transaction still completes
    ar_wait_cfg = 0; r_wait_cfg = 2;
    apb_xfer(1'b0, 32'h0003_0000, 32'h0, 4'h0, 3'b000, 1'b1, rd, er, lat);
    chk("drop rdata", rd, 32'hCAFE_F00D);
    chk("drop err", 32'(er), 32'd0);
    chk("drop lat", 32'(lat), 32'd6);

    // reset while waiting in RD_DATA
    r_wait_cfg = 30;
    @(posedge clk); #1;
    bus.PSEL = 1; bus.PENABLE = 0; bus.PWRITE = 0;
    bus.PADDR = 32'h0002_0010;
    @(posedge clk); #1;
    bus.PENABLE = 1;
    @(negedge clk); @(negedge clk); #1;
    chk("pre-rst rready", 32'(bus.RREADY), 32'd1);
    rst = 1; #1;
    chk("rst rready", 32'({bus.RREADY, bus.ARVALID, bus.PREADY}), 32'd0);
    bus.PSEL = 0; bus.PENABLE = 0;
    @(posedge clk); @(posedge clk); #1 rst = 0;
    r_wait_cfg = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("post-rst no pready", 32'({bus.PREADY, bus.RREADY}), 32'd0);
    apb_xfer(1'b0, 32'h0002_0010, 32'h0, 4'h0, 3'b000, 1'b0, rd, er, lat);
    chk("post-rst rdata", rd, 32'h1234_5678);
    chk("post-rst err", 32'(er), 32'd0);
    chk("post-rst lat", 32'(lat), 32'd4);

    // random back-to-back traffic with random stalls
    for (int k = 0; k < 8; k++) sb[k] = 32'h0;
    rand_mode = 1; bresp_cfg = 0; rresp_cfg = 0;
    for (int k = 0; k < 100; k++) begin
      idx = int'($urandom_range(7, 0));
      a = 32'h0010_0000 + 32'(idx) * 4;
      if ($urandom_range(1, 0) == 1) begin
        rd = $urandom;
        sb[idx] = rd;
        apb_xfer(1'b1, a, rd, 4'hF, 3'b000, 1'b0, rd, er, lat);
      end else begin
        apb_xfer(1'b0, a, 32'h0, 4'h0, 3'b000, 1'b0, rd, er, lat);
        chk($sformatf("rnd%0d rdata", k), rd, sb[idx]);
      end
      chk($sformatf("rnd%0d err", k), 32'(er), 32'd0);
    end
    apb_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/apb_to_axi_bridge.md
APB_TO_AXI_BRIDGE -- requirements
Module: apb_to_axi_bridge

Interface
REQ-001 SHALL have parameter AXI_WIDTH_ID, default 4, width of all AXI ID fields.
REQ-002 SHALL have parameter AXI_WIDTH_AD, default 32, AXI and APB address width.
REQ-003 SHALL have parameter AXI_WIDTH_DA, default 32, data width; the only supported value is 32, and AXI_WIDTH_DS = AXI_WIDTH_DA/8.
REQ-004 SHALL have parameter AXI_ID, default 0, the constant value driven on AWID, WID and ARID.
REQ-005 SHALL have port PCLK  input  1  single clock for the APB and AXI sides.
REQ-006 SHALL have port PRESET  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have APB responder inputs: PSEL 1, PENABLE 1, PWRITE 1, PADDR AXI_WIDTH_AD, PWDATA 32, PSTRB 4, PPROT 3.
REQ-008 SHALL have APB responder outputs: PRDATA 32, PREADY 1, PSLVERR 1.
REQ-009 SHALL have AW channel outputs AWID, AWADDR, AWLEN 4, AWSIZE 3, AWBURST 2, AWPROT 3 and AWVALID, plus input AWREADY.
REQ-010 SHALL have W channel outputs WID, WDATA 32, WSTRB 4, WLAST and WVALID, plus input WREADY.
REQ-011 SHALL have B channel inputs BID and BRESP 2 and BVALID, plus output BREADY.
REQ-012 SHALL have AR channel outputs ARID, ARADDR, ARLEN 4, ARSIZE 3, ARBURST 2, ARPROT 3 and ARVALID, plus input ARREADY.
REQ-013 SHALL have R channel inputs RID, RDATA 32, RRESP 2, RLAST and RVALID, plus output RREADY.

Function
REQ-014 SHALL drive these constant outputs: AWLEN = ARLEN = 0, AWSIZE = ARSIZE = 3'b010, AWBURST = ARBURST = 2'b01, WLAST = 1.
REQ-015 SHALL implement an FSM with states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA and DONE.
REQ-016 SHALL, in IDLE when PSEL=1 and PENABLE=0, capture PADDR, PWDATA, PSTRB, PPROT and PWRITE, then go to WR_REQ if PWRITE=1, else to RD_REQ.
REQ-017 SHALL, in WR_REQ, assert AWVALID and WVALID in the same cycle, each registered; each SHALL drop independently on its own handshake; the FSM SHALL go to WR_RESP once both handshakes have completed, in whatever order or cycle.
REQ-018 SHALL, in WR_RESP, hold BREADY=1; when BVALID=1, latch PSLVERR_next = BRESP[1] and go to DONE.
REQ-019 SHALL, in RD_REQ, assert ARVALID until ARREADY is seen, then go to RD_DATA.
REQ-020 SHALL, in RD_DATA, hold RREADY=1; when RVALID=1, latch RDATA into PRDATA, latch PSLVERR_next = RRESP[1], and go to DONE.
REQ-021 SHALL, in DONE, assert PREADY=1 for exactly one cycle with PSLVERR valid, then return to IDLE.
REQ-022 SHALL keep PREADY=0 in every state other than DONE, so each APB access phase stretches until the AXI transaction completes.
REQ-023 SHALL keep AWVALID, WVALID and ARVALID asserted, with stable payload, until their handshakes; VALID SHALL never depend combinationally on READY.
REQ-024 SHALL have minimum latency, from the APB setup cycle to PREADY with zero-wait AXI, of 4 cycles for a write and 4 cycles for a read.
REQ-025 SHALL keep PRDATA at its last read value after a write; PRDATA is meaningful only when PREADY=1 and PWRITE=0.
REQ-026 SHALL treat BID and RID as don't-care, since only one transaction is outstanding at any time.
REQ-027 SHALL ignore BVALID and RVALID when they arrive outside WR_RESP and RD_DATA respectively, with no state change.
REQ-028 SHALL ignore PSEL deassertion during an access; a started AXI transaction always completes.
REQ-029 SHALL report PSLVERR=1 for both SLVERR (2'b10) and DECERR (2'b11) responses, and PSLVERR=0 for OKAY and EXOKAY.

Reset
REQ-030 SHALL, while PRESET=1, force the FSM to IDLE and clear all outputs to 0, with AWLEN/ARLEN, AWSIZE/ARSIZE, AWBURST/ARBURST, WLAST and the ID outputs at their constant values.
REQ-031 SHALL, when reset is asserted mid-transaction, drop every VALID and READY output immediately and abandon the transaction, with no response on APB.

Verification
REQ-032 SHALL be verified by: APB write 0x0001_0004 <- 0xDEADBEEF with PSTRB=4'hF, zero-wait AXI -> one AW/W handshake with matching address and data, BREADY seen, PREADY after 4 cycles, PSLVERR=0.
REQ-033 SHALL be verified by: APB read 0x0002_0010 with RDATA=0x12345678, RRESP=0 -> PRDATA=0x12345678 with PREADY, PSLVERR=0.
REQ-034 SHALL be verified by: AWREADY delayed 3 cycles and WREADY immediate -> WVALID drops after 1 cycle, AWVALID holds until the 4th cycle, and exactly one B handshake follows.
REQ-035 SHALL be verified by: a write with BRESP=2'b10, and a separate read with RRESP=2'b11 -> PSLVERR=1 on each.
REQ-036 SHALL be verified by: PRESET pulsed while in RD_DATA -> RREADY=0 and the FSM in IDLE; a following read then completes normally.
REQ-037 SHALL be verified by: 100 back-to-back random read and write accesses against an AXI memory model with random stalls -> every read returns the last value written to its address.
